// File: rtl/date_time_counter_if.sv
// Calendar clock bundle: BCD date/time fields ([1] tens, [0] ones) plus day of week.
interface if_date_time;
  logic [1:0][3:0] second;
  logic [1:0][3:0] minute;
  logic [1:0][3:0] hour;
  logic [1:0][3:0] day;
  logic [1:0][3:0] month;
  logic [1:0][3:0] year;
  logic [2:0]      day_of_week;

  modport producer (output second, minute, hour, day, month, year, day_of_week);
  modport consumer (input  second, minute, hour, day, month, year, day_of_week);
endinterface

// File: rtl/date_time_counter.sv
// BCD date/time counter for the 2000-2099 century, set from DCF77 telegrams,
// with a holdover window after which the time is reported as no longer synced.
module date_time_counter #(
  parameter int HOLDOVER_MIN = 1440
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick_1hz,
  input  logic            load,
  input  logic [1:0][3:0] ld_minute,
  input  logic [1:0][3:0] ld_hour,
  input  logic [1:0][3:0] ld_day,
  input  logic [1:0][3:0] ld_month,
  input  logic [1:0][3:0] ld_year,
  input  logic [2:0]      ld_day_of_week,
  if_date_time.producer   clock,
  output logic            synced,
  output logic            load_err
);

  localparam logic [10:0] HOLD_LIM = 11'(HOLDOVER_MIN);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic is_leap(input logic [7:0] y);
    logic r;
    if (!y[4]) r = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    else       r = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    return r;
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
    logic [7:0] r;
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      8'h02:                      r = is_leap(y) ? 8'h29 : 8'h28;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic [7:0]  sec_r, min_r, hour_r, day_r, mon_r, year_r;
  logic [2:0]  dow_r;
  logic [10:0] hold_r;
  logic        synced_r, load_err_r;

  logic min_carry_s, hour_carry_s, day_carry_s, mon_carry_s, year_carry_s;
  logic ld_fields_ok_s, accept_s, reject_s;

  // Whole carry chain resolves combinationally so every field updates on the same edge.
  assign min_carry_s  = tick_1hz     && (sec_r  == 8'h59);
  assign hour_carry_s = min_carry_s  && (min_r  == 8'h59);
  assign day_carry_s  = hour_carry_s && (hour_r == 8'h23);
  assign mon_carry_s  = day_carry_s  && (day_r  >= days_in_month(mon_r, year_r));
  assign year_carry_s = mon_carry_s  && (mon_r  == 8'h12);

  assign ld_fields_ok_s = digits_ok(ld_minute) && digits_ok(ld_hour) && digits_ok(ld_day)
                       && digits_ok(ld_month) && digits_ok(ld_year)
                       && (ld_minute <= 8'h59) && (ld_hour <= 8'h23)
                       && (ld_month >= 8'h01) && (ld_month <= 8'h12)
                       && (ld_day >= 8'h01) && (ld_day <= days_in_month(ld_month, ld_year))
                       && (ld_day_of_week != 3'd0);
  assign accept_s = load && ld_fields_ok_s;
  assign reject_s = load && !ld_fields_ok_s;

  // Time/date registers, holdover tracking and load error strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_r      <= 8'h00;
      min_r      <= 8'h00;
      hour_r     <= 8'h00;
      day_r      <= 8'h01;
      mon_r      <= 8'h01;
      year_r     <= 8'h00;
      dow_r      <= 3'd0;
      hold_r     <= 11'd0;
      synced_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      load_err_r <= reject_s;
      if (accept_s) begin
        sec_r    <= 8'h00;
        min_r    <= ld_minute;
        hour_r   <= ld_hour;
        day_r    <= ld_day;
        mon_r    <= ld_month;
        year_r   <= ld_year;
        dow_r    <= ld_day_of_week;
        hold_r   <= 11'd0;
        synced_r <= 1'b1;
      end else begin
        if (tick_1hz)     sec_r  <= (sec_r  == 8'h59) ? 8'h00 : bcd_inc(sec_r);
        if (min_carry_s)  min_r  <= (min_r  == 8'h59) ? 8'h00 : bcd_inc(min_r);
        if (hour_carry_s) hour_r <= (hour_r == 8'h23) ? 8'h00 : bcd_inc(hour_r);
        if (day_carry_s)  day_r  <= mon_carry_s ? 8'h01 : bcd_inc(day_r);
        if (mon_carry_s)  mon_r  <= (mon_r  == 8'h12) ? 8'h01 : bcd_inc(mon_r);
        if (year_carry_s) year_r <= (year_r == 8'h99) ? 8'h00 : bcd_inc(year_r);
        // An unknown weekday (0) is kept as unknown.
        if (day_carry_s && (dow_r != 3'd0)) dow_r <= (dow_r == 3'd7) ? 3'd1 : dow_r + 3'd1;
        if (min_carry_s && (hold_r != 11'h7FF)) hold_r <= hold_r + 11'd1;
        if (hold_r >= HOLD_LIM) synced_r <= 1'b0;
      end
    end
  end

  assign clock.second      = sec_r;
  assign clock.minute      = min_r;
  assign clock.hour        = hour_r;
  assign clock.day         = day_r;
  assign clock.month       = mon_r;
  assign clock.year        = year_r;
  assign clock.day_of_week = dow_r;
  assign synced            = synced_r;
  assign load_err          = load_err_r;

endmodule

// File: tb/tb_date_time_counter.sv
// Directed bench for date_time_counter: reset, calendar rollovers, load/tick
// collision, rejected loads, holdover expiry and asynchronous reset.
module tb_date_time_counter;
  logic            clk = 1'b0;
  logic            reset_n;
  logic            tick_1hz;
  logic            load;
  logic [1:0][3:0] ld_minute, ld_hour, ld_day, ld_month, ld_year;
  logic [2:0]      ld_day_of_week;
  logic            synced, load_err;
  int              vectors = 0;
  int              miscompares = 0;

  if_date_time dt ();

  date_time_counter #(.HOLDOVER_MIN(2)) dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .load(load),
    .ld_minute(ld_minute), .ld_hour(ld_hour), .ld_day(ld_day),
    .ld_month(ld_month), .ld_year(ld_year), .ld_day_of_week(ld_day_of_week),
    .clock(dt), .synced(synced), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] s, input logic [7:0] mi,
                          input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                          input logic [7:0] y, input logic [2:0] w);
    chk(tag, {13'd0, dt.second, dt.minute, dt.hour, dt.day, dt.month, dt.year, dt.day_of_week},
             {13'd0, s, mi, h, d, mo, y, w});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
    end
  endtask

  task automatic do_load(input logic [7:0] mi, input logic [7:0] h, input logic [7:0] d,
                         input logic [7:0] mo, input logic [7:0] y, input logic [2:0] w,
                         input logic with_tick);
    ld_minute = mi; ld_hour = h; ld_day = d; ld_month = mo; ld_year = y;
    ld_day_of_week = w;
    load = 1'b1;
    tick_1hz = with_tick;
    @(negedge clk);
    load = 1'b0;
    tick_1hz = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tick_1hz = 1'b0; load = 1'b0;
    ld_minute = 8'h00; ld_hour = 8'h00; ld_day = 8'h01; ld_month = 8'h01; ld_year = 8'h00;
    ld_day_of_week = 3'd0;

    // Reset with no strobes
    @(negedge clk); @(negedge clk);
    chk_time("reset_time", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0);
    chk("reset_synced", synced, 1'b0);
    chk("reset_load_err", load_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_time("post_reset_time", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0);

    // Year rollover
    do_load(8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 3'd7, 1'b0);
    chk_time("load_dec31", 8'h00, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 3'd7);
    chk("load_synced", synced, 1'b1);
    ticks(59);
    chk_time("dec31_235959", 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 3'd7);
    ticks(1);
    chk_time("year_rollover", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd1);
    chk("rollover_synced", synced, 1'b1);

    // February and 30-day month
    do_load(8'h59, 8'h23, 8'h28, 8'h02, 8'h24, 3'd3, 1'b0);
    ticks(60);
    chk_time("feb_leap_24", 8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 8'h24, 3'd4);
    do_load(8'h59, 8'h23, 8'h28, 8'h02, 8'h25, 3'd5, 1'b0);
    ticks(60);
    chk_time("feb_common_25", 8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h25, 3'd6);
    do_load(8'h59, 8'h23, 8'h30, 8'h04, 8'h26, 3'd4, 1'b0);
    ticks(60);
    chk_time("apr30_26", 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'h26, 3'd5);

    // Load coinciding with a tick at second 37
    ticks(37);
    chk_time("sec37", 8'h37, 8'h00, 8'h00, 8'h01, 8'h05, 8'h26, 3'd5);
    do_load(8'h34, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7, 1'b1);
    chk_time("load_beats_tick", 8'h00, 8'h34, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7);
    chk("load_tick_err", load_err, 1'b0);

    // Rejected loads
    ticks(5);
    do_load(8'h60, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7, 1'b0);
    chk("min60_err", load_err, 1'b1);
    chk_time("min60_unchanged", 8'h05, 8'h34, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7);
    @(negedge clk);
    chk("min60_err_one_cycle", load_err, 1'b0);
    do_load(8'h34, 8'h12, 8'h31, 8'h04, 8'h25, 3'd2, 1'b1);
    chk("apr31_err", load_err, 1'b1);
    chk_time("apr31_tick_kept", 8'h06, 8'h34, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7);
    @(negedge clk);
    chk("apr31_err_one_cycle", load_err, 1'b0);
    do_load(8'h1A, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7, 1'b0);
    chk("nonbcd_err", load_err, 1'b1);
    do_load(8'h34, 8'h12, 8'h15, 8'h06, 8'h25, 3'd0, 1'b0);
    chk("dow0_err", load_err, 1'b1);
    chk_time("bad_loads_unchanged", 8'h06, 8'h34, 8'h12, 8'h15, 8'h06, 8'h25, 3'd7);

    // Holdover expiry with limit 2
    do_load(8'h00, 8'h10, 8'h01, 8'h01, 8'h25, 3'd3, 1'b0);
    chk("hold_load_synced", synced, 1'b1);
    ticks(60);
    chk_time("hold_min1", 8'h00, 8'h01, 8'h10, 8'h01, 8'h01, 8'h25, 3'd3);
    chk("hold_after_1st", synced, 1'b1);
    ticks(60);
    chk_time("hold_min2", 8'h00, 8'h02, 8'h10, 8'h01, 8'h01, 8'h25, 3'd3);
    chk("hold_at_2nd_carry", synced, 1'b1);
    @(negedge clk);
    chk("hold_synced_cleared", synced, 1'b0);
    ticks(5);
    chk_time("hold_free_run", 8'h05, 8'h02, 8'h10, 8'h01, 8'h01, 8'h25, 3'd3);
    chk("hold_stays_unsynced", synced, 1'b0);

    // Asynchronous reset while a full cascade is pending
    do_load(8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 3'd7, 1'b0);
    ticks(59);
    tick_1hz = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk_time("async_reset", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0);
    chk("async_reset_synced", synced, 1'b0);
    @(negedge clk);
    chk_time("reset_ignores_tick", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0);
    tick_1hz = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    ticks(1);
    chk_time("first_tick_after_reset", 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0);
    chk("after_reset_load_err", load_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
